// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width default, select width and select-class decode.
// Used by the sequencer and by anything that models the external ALU.
package alu_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int SEL_W     = 5;

  typedef enum logic [1:0] {
    SEL_ARITH = 2'b00,
    SEL_SHIFT = 2'b01,
    SEL_LOGIC = 2'b10
  } sel_class_e;

  function automatic sel_class_e sel_class(input logic [SEL_W-1:0] sel);
    return sel_class_e'(sel[4:3]);
  endfunction
endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous result FIFO, WIDTH x DEPTH, with count-based full/empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_res_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != DEPTH_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
endmodule

// File: rtl/alu_op_sequencer.sv
// Issues commands to an external combinational ALU through one register stage and
// queues its results in order. Optional accumulator chaining under `ALU_ACC_CHAIN_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int RES_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_f,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);
  logic             issue_vld_q, issue_vld_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic             fifo_full, fifo_empty;
  logic             pop, capture, accept;
  logic [WIDTH-1:0] op_a;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready. cmd_ready frees up in the same cycle the issue stage is captured.
  assign pop       = res_ready && !fifo_empty;
  assign capture   = issue_vld_q && (!fifo_full || pop);
  assign cmd_ready = !issue_vld_q || capture;
  assign accept    = cmd_valid && cmd_ready;

`ifdef ALU_ACC_CHAIN_EN
  logic [WIDTH-1:0] acc_q, acc_d;

  // A chained command arriving while its predecessor is captured takes alu_f directly.
  always_comb begin
    acc_d = acc_q;
    if (capture) acc_d = alu_f;
    op_a = cmd_a;
    if (cmd_use_acc) op_a = capture ? alu_f : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`else
  logic unused_use_acc;
  assign unused_use_acc = cmd_use_acc;
  assign op_a           = cmd_a;
`endif

  always_comb begin
    issue_vld_d = issue_vld_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    if (capture) issue_vld_d = 1'b0;
    if (accept) begin
      issue_vld_d = 1'b1;
      alu_a_d     = op_a;
      alu_b_d     = cmd_b;
      alu_sel_d   = cmd_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_vld_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
    end else begin
      issue_vld_q <= issue_vld_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
    end
  end

  alu_res_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .pop   (pop),
    .wdata (alu_f),
    .rdata (res_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = !fifo_empty;
  assign busy      = issue_vld_q || !fifo_empty;
endmodule
